// File: rtl/stream_fifo_if.sv
// stream_channel: AXI-Stream beat bundle (valid/ready plus id, dest, data,
// strb, keep, last, user). master drives the beat, slave drives t_ready.
interface stream_channel #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 4
);
    logic                    t_valid;
    logic                    t_ready;
    logic [ID_WIDTH-1:0]     t_id;
    logic [DEST_WIDTH-1:0]   t_dest;
    logic [DATA_WIDTH-1:0]   t_data;
    logic [DATA_WIDTH/8-1:0] t_strb;
    logic [DATA_WIDTH/8-1:0] t_keep;
    logic                    t_last;
    logic [USER_WIDTH-1:0]   t_user;

    modport master (
        output t_valid, t_id, t_dest, t_data,
        output t_strb, t_keep, t_last, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_id, t_dest, t_data,
        input  t_strb, t_keep, t_last, t_user,
        output t_ready
    );
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: registered AXI-Stream beat FIFO, one beat per cycle.
// Ports: clk, rst (async high), master (upstream in), slave (downstream out),
// count (beats stored).
module stream_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    stream_channel.slave               master,
    stream_channel.master              slave,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int IW = $bits(master.t_id);
    localparam int DW = $bits(master.t_data);
    localparam int SW = $bits(master.t_strb);
    localparam int TW = $bits(master.t_dest);
    localparam int UW = $bits(master.t_user);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $fatal(1, "stream_fifo: DEPTH must be a power of two >= 2");
    end

    if (IW != $bits(slave.t_id) || DW != $bits(slave.t_data) ||
        SW != $bits(slave.t_strb) || TW != $bits(slave.t_dest) ||
        UW != $bits(slave.t_user)) begin : g_width_chk
        $fatal(1, "stream_fifo: master/slave width mismatch");
    end

    typedef struct packed {
        logic [IW-1:0] id;
        logic [TW-1:0] dest;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [SW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    beat_t         mem [DEPTH];
    beat_t         wr_beat;
    beat_t         head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          ready_q;
    logic          valid_q;
    logic          wr_en;
    logic          rd_en;

    assign wr_en = master.t_valid && ready_q;
    assign rd_en = valid_q && slave.t_ready;

    always_comb begin
        wr_beat      = '0;
        wr_beat.id   = master.t_id;
        wr_beat.dest = master.t_dest;
        wr_beat.data = master.t_data;
        wr_beat.strb = master.t_strb;
        wr_beat.keep = master.t_keep;
        wr_beat.last = master.t_last;
        wr_beat.user = master.t_user;
    end

    always_comb begin
        count_nxt = count;
        unique case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Handshake flags are precomputed from next count so both outputs
    // come straight from flops with no cross-side combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            count   <= count_nxt;
            ready_q <= count_nxt < CW'(DEPTH);
            valid_q <= count_nxt != '0;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Storage is cleared on reset so the slave payload reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_beat;
        end
    end

    assign head = mem[rd_ptr];

    assign master.t_ready = ready_q;
    assign slave.t_valid  = valid_q;
    assign slave.t_id     = head.id;
    assign slave.t_dest   = head.dest;
    assign slave.t_data   = head.data;
    assign slave.t_strb   = head.strb;
    assign slave.t_keep   = head.keep;
    assign slave.t_last   = head.last;
    assign slave.t_user   = head.user;
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: random and directed stimulus for stream_fifo, checked
// against a queue-based reference model of the beat store.
module tb_stream_fifo;
    localparam int DEPTH = 4;
    localparam int BW    = 53;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count;

    stream_channel #(.ID_WIDTH(4), .DATA_WIDTH(32),
                     .DEST_WIDTH(4), .USER_WIDTH(4)) up ();
    stream_channel #(.ID_WIDTH(4), .DATA_WIDTH(32),
                     .DEST_WIDTH(4), .USER_WIDTH(4)) dn ();

    stream_fifo #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .master (up),
        .slave  (dn),
        .count  (count)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic          live  = 1'b0;
    logic [BW-1:0] q [$];
    logic [31:0]   out_log [$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack_up();
        return {up.t_id, up.t_dest, up.t_data, up.t_strb,
                up.t_keep, up.t_last, up.t_user};
    endfunction

    function automatic logic [BW-1:0] pack_dn();
        return {dn.t_id, dn.t_dest, dn.t_data, dn.t_strb,
                dn.t_keep, dn.t_last, dn.t_user};
    endfunction

    task automatic drive(logic v, logic [31:0] d, logic l);
        up.t_valid = v;
        up.t_id    = 4'($urandom);
        up.t_dest  = 4'($urandom);
        up.t_data  = d;
        up.t_strb  = 4'($urandom);
        up.t_keep  = 4'($urandom);
        up.t_last  = l;
        up.t_user  = 4'($urandom);
    endtask

    // One clock: check outputs against the model, then advance it.
    task automatic cycle(output logic wr);
        logic          exp_rdy;
        logic          exp_vld;
        logic          rd;
        logic          rs;
        logic [BW-1:0] beat;
        exp_rdy = live && (q.size() < DEPTH);
        exp_vld = q.size() != 0;
        check("ready", 64'(up.t_ready), 64'(exp_rdy));
        check("valid", 64'(dn.t_valid), 64'(exp_vld));
        check("count", 64'(count), 64'(q.size()));
        if (exp_vld) check("head", 64'(pack_dn()), 64'(q[0]));
        wr   = up.t_valid && exp_rdy;
        rd   = exp_vld && dn.t_ready;
        beat = pack_up();
        rs   = rst;
        if (rd) out_log.push_back(dn.t_data);
        @(posedge clk);
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(beat);
        live = !rs;
        #1;
    endtask

    task automatic tick();
        logic w;
        cycle(w);
    endtask

    task automatic drain();
        up.t_valid = 1'b0;
        dn.t_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("drained", 64'(q.size()), 64'd0);
        tick();
    endtask

    logic [31:0] fill_exp [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

    initial begin
        logic acc;
        int   base;
        int   writes;
        up.t_valid = 1'b0;
        up.t_id = '0; up.t_dest = '0; up.t_data = '0; up.t_strb = '0;
        up.t_keep = '0; up.t_last = 1'b0; up.t_user = '0;
        dn.t_ready = 1'b0;
        #1;

        // Reset held three cycles with upstream valid asserted.
        drive(1'b1, 32'hdead, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("rst_pay", 64'(pack_dn()), 64'd0);
            tick();
        end
        rst = 1'b0;
        up.t_valid = 1'b0;
        tick();
        tick();

        // Fill to full with downstream stalled.
        out_log.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_exp[i], i == 3);
            tick();
        end
        drive(1'b1, 32'h55, 1'b0);
        tick();
        tick();
        check("full_cnt", 64'(count), 64'd4);
        dn.t_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) cycle(acc);
        check("acc55", 64'(acc), 64'd1);
        drain();
        check("fill_n", 64'(out_log.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            if (i < out_log.size())
                check("fill_ord", 64'(out_log[i]), 64'(fill_exp[i]));

        // Streaming, both sides ready.
        dn.t_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'(i), i[0]);
            tick();
            if (i > 0) check("stream_cnt", 64'(count), 64'd1);
        end
        drain();

        // Full with a single-cycle read.
        dn.t_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, 32'h1ff, 1'b1);
        tick();
        dn.t_ready = 1'b1;
        tick();
        check("fr_cnt3", 64'(count), 64'd3);
        check("fr_rdy", 64'(up.t_ready), 64'd1);
        dn.t_ready = 1'b0;
        tick();
        up.t_valid = 1'b0;
        check("fr_cnt4", 64'(count), 64'd4);
        tick();
        drain();

        // Random traffic across many pointer wraps.
        writes = 0;
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4000 && writes < 1000; i++) begin
            if (!up.t_valid || acc)
                drive(1'($urandom), $urandom, 1'($urandom));
            dn.t_ready = 1'($urandom);
            cycle(acc);
            if (acc) writes++;
        end
        check("rand_wr", 64'(writes), 64'd1000);
        drain();

        // Asynchronous reset with three beats stored.
        dn.t_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b0);
            tick();
        end
        check("pre_cnt", 64'(count), 64'd3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 64'(dn.t_valid), 64'd0);
        check("ar_count", 64'(count), 64'd0);
        check("ar_ready", 64'(up.t_ready), 64'd0);
        q.delete();
        live = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 32'hbad, 1'b1);
        tick();
        check("ar_pay", 64'(pack_dn()), 64'd0);
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h300, 1'b0);
        tick();
        tick();
        up.t_valid = 1'b0;
        base = out_log.size();
        dn.t_ready = 1'b1;
        tick();
        check("ar_first_n", 64'(out_log.size()), 64'(base + 1));
        if (out_log.size() > base)
            check("ar_first", 64'(out_log[base]), 64'h300);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
